// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupling FIFO between the fetch stage and the IF/ID pipeline register.
//   It holds fetched {pc, inst} pairs so an ID-side stall does not immediately
//   back-pressure instruction memory. A control-flow redirect (flush) empties
//   the queue in one edge.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   flush      redirect: discard every entry, plus any push/pop this cycle
//   in_valid   fetch offers {in_pc, in_inst} this cycle
//   in_ready   queue can accept an entry (not full)
//   in_pc      PC of the offered instruction
//   in_inst    offered instruction word
//   out_valid  head entry available (not empty)
//   out_ready  IF/ID consumes the head this cycle
//   out_pc     PC of the head entry, 0 while empty
//   out_inst   instruction of the head entry, 0 while empty
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // Status is derived only from registered state, so nothing on the input
    // side can combinationally reach an output.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & ~w_full;
    assign w_pop     = out_ready & ~w_empty;

    // Head is forced to zero while empty so stale array contents never leak.
    assign out_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign out_inst = w_empty ? '0 : r_inst_mem[r_rd_ptr];
    assign count    = r_count;

    // Storage: one write-enabled register per entry, no reset needed since
    // an entry is only ever read after it has been written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && !flush && (r_wr_ptr == PTR_W'(gi))) begin
                    r_pc_mem[gi]   <= in_pc;
                    r_inst_mem[gi] <= in_inst;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Redirect wins over any handshake in the same cycle.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc = '0;
    logic [INST_W-1:0] in_inst = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic [$clog2(DEPTH):0] count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t mq[$];

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of accepted entries, bounded by DEPTH.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else if (flush) begin
            if (mq.size() != 0 || in_valid)
                $display("txn flush: dropped %0d entries", mq.size());
            mq.delete();
        end else begin
            bit do_push;
            bit do_pop;
            ent_t e;
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = out_ready && (mq.size() > 0);
            if (do_pop) begin
                e = mq.pop_front();
                $display("txn pop  pc=%08h inst=%08h", e.pc, e.inst);
            end
            if (do_push) begin
                e.pc   = in_pc;
                e.inst = in_inst;
                mq.push_back(e);
                $display("txn push pc=%08h inst=%08h", in_pc, in_inst);
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",     64'(count),     64'(mq.size()));
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
            chk("out_pc",    64'(out_pc),    (mq.size() != 0) ? 64'(mq[0].pc)   : 64'd0);
            chk("out_inst",  64'(out_inst),  (mq.size() != 0) ? 64'(mq[0].inst) : 64'd0);
        end
    end

    // Advance one edge; inputs change and literal checks happen 1 time unit
    // after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [ADDR_W-1:0] pc,
                          input logic [INST_W-1:0] inst, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        // Reset then idle.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        cycle();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", 64'(out_pc), 64'd0);

        // Fill to DEPTH with out_ready low.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(4 * i), 32'(32'h11 + i), 1'b0, 1'b0);
            cycle();
        end
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        set_in(1'b1, 32'h10, 32'h15, 1'b0, 1'b0);
        cycle();
        chk("full_refuse_count", 64'(count), 64'd4);

        // Drain from full: strict order.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, '0, '0, 1'b1, 1'b0);
            chk("drain_pc", 64'(out_pc), 64'(4 * i));
            chk("drain_inst", 64'(out_inst), 64'(32'h11 + i));
            cycle();
        end
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);

        // Streaming push+pop: head is always the entry pushed one edge earlier.
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 32'(32'h100 + 4 * k), 32'(32'hA000 + k), 1'b1, 1'b0);
            cycle();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(out_pc), 64'(32'h100 + 4 * k));
        end
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        chk("stream_empty", 64'(count), 64'd0);

        // Flush with three entries while a push and pop are both offered.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(32'h20 + 4 * i), 32'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("preflush_count", 64'(count), 64'd3);
        set_in(1'b1, 32'h40, 32'h44, 1'b1, 1'b1);
        cycle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        set_in(1'b1, 32'h80, 32'h88, 1'b0, 1'b0);
        cycle();
        chk("postflush_pc", 64'(out_pc), 64'h80);
        chk("postflush_count", 64'(count), 64'd1);
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();

        // Full: pop with push offered in the same cycle.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(32'h200 + 4 * i), 32'(32'h50 + i), 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b1, 32'h210, 32'h54, 1'b1, 1'b0);
        cycle();
        chk("fullpop_count", 64'(count), 64'd3);
        chk("fullpop_head", 64'(out_pc), 64'h204);
        set_in(1'b1, 32'h210, 32'h54, 1'b0, 1'b0);
        cycle();
        chk("refill_count", 64'(count), 64'd4);

        // Asynchronous reset between edges with a full queue.
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        #1;
        rst = 1'b0;
        cycle();

        // Randomized traffic against the reference.
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
            cycle();
        end
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (DEPTH + 1) cycle();
        chk("final_empty", 64'(count), 64'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
